// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of one UART byte transmitter for N_REQ byte streams.
// Define UART_ARB_HEADER_EN to prefix each message with 8'hA0 | owner.
module uart_tx_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   grant,
   output logic               tx_send,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   output logic               active
);

`ifdef UART_ARB_HEADER_EN
   localparam bit HDR_EN = 1'b1;
`else
   localparam bit HDR_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      FETCH,
      WAIT_HI,
      WAIT_LO
   } state_t;

   state_t state, state_n;

   logic [N_REQ-1:0] grant_n;
   logic [IDX_W-1:0] gidx, gidx_n;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
   logic [IDX_W-1:0] win_idx;
   logic             win_found;
   int               best;
   logic             tx_send_n;
   logic [7:0]       tx_data_n;
   logic             last_r, last_n;
   logic             hdr_done, hdr_n;
   logic [7:0]       bytes [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign bytes[i] = req_data[8*i +: 8];
   end

   // Winner is the valid index at the smallest wrapped distance from rr_ptr.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      best      = N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_valid[i] &&
             ((i + N_REQ - int'(rr_ptr)) % N_REQ) < best) begin
            best      = (i + N_REQ - int'(rr_ptr)) % N_REQ;
            win_idx   = IDX_W'(i);
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_n   = state;
      grant_n   = grant;
      gidx_n    = gidx;
      rr_ptr_n  = rr_ptr;
      tx_send_n = 1'b0;
      tx_data_n = tx_data;
      last_n    = last_r;
      hdr_n     = hdr_done;
      unique case (state)
         IDLE: begin
            if (win_found && !tx_busy) begin
               grant_n = N_REQ'(1) << win_idx;
               gidx_n  = win_idx;
               state_n = HDR_EN ? HDR : FETCH;
            end
         end
         HDR: begin
            tx_data_n = 8'hA0 | 8'(gidx);
            tx_send_n = 1'b1;
            hdr_n     = 1'b1;
            state_n   = WAIT_HI;
         end
         FETCH: begin
            if (req_valid[gidx]) begin
               tx_data_n = bytes[gidx];
               tx_send_n = 1'b1;
               last_n    = req_last[gidx];
               state_n   = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (tx_busy) state_n = WAIT_LO;
         end
         WAIT_LO: begin
            if (!tx_busy) begin
               if (hdr_done) begin
                  hdr_n   = 1'b0;
                  state_n = FETCH;
               end else if (!last_r) begin
                  state_n = FETCH;
               end else begin
                  grant_n  = '0;
                  rr_ptr_n = (gidx == IDX_W'(N_REQ-1)) ?
                             '0 : gidx + 1'b1;
                  state_n  = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= '0;
         gidx     <= '0;
         rr_ptr   <= '0;
         tx_send  <= 1'b0;
         tx_data  <= 8'h00;
         last_r   <= 1'b0;
         hdr_done <= 1'b0;
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         gidx     <= gidx_n;
         rr_ptr   <= rr_ptr_n;
         tx_send  <= tx_send_n;
         tx_data  <= tx_data_n;
         last_r   <= last_n;
         hdr_done <= hdr_n;
      end
   end

   assign req_ready = (state == FETCH) ? grant : '0;
   assign active    = (state != IDLE);

endmodule
